adc_scan_scheduler: RTL and testbench

Periodic multi-channel scan controller for the SPI ADC front end. On every sample-period tick it walks an enabled-channel mask in ascending order, issues one conversion request per channel to the SPI transaction engine, and stores each 12-bit result in a per-channel result register. The LED and display logic read those registers. It sits between the prescaled system clock domain and the SPI state machine, and is the only block that starts SPI transactions.

---
 rtl/adc_scan_scheduler_pkg.sv | 17 +
 rtl/adc_scan_scheduler_period_timer.sv | 31 +++
 rtl/adc_scan_scheduler.sv | 172 +++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_scan_scheduler_pkg.sv
// Shared types and defaults for the ADC scan scheduler and its period timer.
package adc_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_STORE
  } sched_state_e;

  localparam int DEF_NUM_CH  = 8;
  localparam int CH_W        = $clog2(DEF_NUM_CH);
  localparam int DEF_PERIOD  = 10000;
  localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/adc_scan_scheduler_period_timer.sv
// Free-running sample-period timer: one-cycle tick every PERIOD cycles while enabled.
module period_timer
  import adc_sched_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int              CNT_W = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_count;

  // Held at zero while disabled so a re-enable always gives a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!enable || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = enable && (r_count == LAST);

endmodule

// File: rtl/adc_scan_scheduler.sv
// Periodic multi-channel ADC scan controller: walks the enabled channels on each tick,
// drives the SPI engine one conversion at a time and keeps the latest result per channel.
module adc_scan_scheduler
  import adc_sched_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int DATA_W  = 12,
  parameter int PERIOD  = DEF_PERIOD,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         chan_mask,
  input  logic                      clr_err,
  input  logic                      spi_busy,
  input  logic                      spi_done,
  input  logic [DATA_W-1:0]         spi_data,
  output logic                      spi_start,
  output logic [$clog2(NUM_CH)-1:0] spi_chan,
  output logic                      res_valid,
  output logic [$clog2(NUM_CH)-1:0] res_chan,
  output logic [DATA_W-1:0]         res_data,
  output logic                      scan_done,
  output logic                      busy,
  input  logic [$clog2(NUM_CH)-1:0] rd_chan,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      timeout_err,
  output logic                      overrun_err
);

  localparam int                CHAN_W  = $clog2(NUM_CH);
  localparam int                TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [NUM_CH-1:0] ONE     = NUM_CH'(1);

  sched_state_e      r_state;
  logic [NUM_CH-1:0] r_pending;
  logic [CHAN_W-1:0] r_cur;
  logic [TO_W-1:0]   r_tcnt;
  logic [DATA_W-1:0] r_result [NUM_CH];
  logic              r_res_valid;
  logic [CHAN_W-1:0] r_res_chan;
  logic [DATA_W-1:0] r_res_data;
  logic              r_to_done;
  logic              r_timeout_err;
  logic              r_overrun_err;

  logic              w_tick;
  logic [CHAN_W-1:0] w_low_chan;
  logic [NUM_CH-1:0] w_pending_next;
  logic              w_last;
  logic              w_start;
  logic              w_to_fire;

  period_timer #(
    .PERIOD (PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (w_tick)
  );

  // Lowest set bit wins, so channels are visited in ascending order.
  always_comb begin
    w_low_chan = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_low_chan = CHAN_W'(i);
      end
    end
  end

  assign w_pending_next = r_pending & ~(ONE << r_cur);
  assign w_last         = (w_pending_next == '0) || !enable;
  assign w_start        = (r_state == ST_ISSUE) && !spi_busy;
  // Issuing and a returning result both take priority over an expiring budget.
  assign w_to_fire      = (((r_state == ST_ISSUE) && spi_busy) ||
                           ((r_state == ST_WAIT_DONE) && !spi_done)) &&
                          (r_tcnt >= TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pending     <= '0;
      r_cur         <= '0;
      r_tcnt        <= '0;
      r_res_valid   <= 1'b0;
      r_res_chan    <= '0;
      r_res_data    <= '0;
      r_to_done     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_result[i] <= '0;
      end
    end else begin
      r_res_valid <= 1'b0;
      r_to_done   <= 1'b0;

      if (w_to_fire) begin
        r_timeout_err <= 1'b1;
      end else if (clr_err) begin
        r_timeout_err <= 1'b0;
      end

      if (w_tick && (r_state != ST_IDLE)) begin
        r_overrun_err <= 1'b1;
      end else if (clr_err) begin
        r_overrun_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_tick && (chan_mask != '0)) begin
            r_pending <= chan_mask;
            r_state   <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          r_cur   <= w_low_chan;
          r_tcnt  <= '0;
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (w_start) begin
            r_state <= ST_WAIT_DONE;
          end else if (w_to_fire) begin
            r_pending <= w_pending_next;
            r_to_done <= w_last;
            r_state   <= w_last ? ST_IDLE : ST_SELECT;
          end
        end
        ST_WAIT_DONE: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (spi_done) begin
            r_res_valid <= 1'b1;
            r_res_chan  <= r_cur;
            r_res_data  <= spi_data;
            r_state     <= ST_STORE;
          end else if (w_to_fire) begin
            r_pending <= w_pending_next;
            r_to_done <= w_last;
            r_state   <= w_last ? ST_IDLE : ST_SELECT;
          end
        end
        ST_STORE: begin
          r_result[r_cur] <= r_res_data;
          r_pending       <= w_pending_next;
          r_state         <= w_last ? ST_IDLE : ST_SELECT;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi_start   = w_start;
  assign spi_chan    = r_cur;
  assign res_valid   = r_res_valid;
  assign res_chan    = r_res_chan;
  assign res_data    = r_res_data;
  assign scan_done   = ((r_state == ST_STORE) && w_last) || r_to_done;
  assign busy        = (r_state != ST_IDLE);
  assign rd_data     = r_result[rd_chan];
  assign timeout_err = r_timeout_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler: vector table of single scans plus hand-built
// sequences for timeout timing, SPI back-pressure and mid-transaction reset.
module tb_adc_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  chan_mask;
  logic        clr_err;
  logic        spi_busy;
  logic        spi_done;
  logic [11:0] spi_data;
  logic        spi_start;
  logic [2:0]  spi_chan;
  logic        res_valid;
  logic [2:0]  res_chan;
  logic [11:0] res_data;
  logic        scan_done;
  logic        busy;
  logic [2:0]  rd_chan;
  logic [11:0] rd_data;
  logic        timeout_err;
  logic        overrun_err;

  int tests = 0;
  int fails = 0;

  int          lat = 1;
  logic [7:0]  hang = 8'h00;
  logic [11:0] base = 12'h000;
  bit          armed = 1'b0;
  int          remain = 0;
  logic [2:0]  armChan = 3'd0;
  logic [2:0]  doneChan = 3'd0;

  int          startCnt = 0;
  int          validCnt = 0;
  int          doneCnt = 0;
  int          busyCnt = 0;
  logic [2:0]  startQ[$];
  bit          prevDone = 1'b0;
  logic [11:0] prevData = 12'h000;
  logic [2:0]  prevChan = 3'd0;
  logic [11:0] expRes[8];

  typedef struct {
    logic [7:0]  mask;
    int          lat;
    logic [11:0] base;
    int          expStarts;
    int          expValids;
    bit          expOv;
  } vec_t;

  vec_t vecs[4];

  adc_scan_scheduler #(
    .NUM_CH  (8),
    .DATA_W  (12),
    .PERIOD  (20),
    .TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .chan_mask   (chan_mask),
    .clr_err     (clr_err),
    .spi_busy    (spi_busy),
    .spi_done    (spi_done),
    .spi_data    (spi_data),
    .spi_start   (spi_start),
    .spi_chan    (spi_chan),
    .res_valid   (res_valid),
    .res_chan    (res_chan),
    .res_data    (res_data),
    .scan_done   (scan_done),
    .busy        (busy),
    .rd_chan     (rd_chan),
    .rd_data     (rd_data),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // SPI engine model: answers base+chan lat cycles after a request, unless the channel hangs.
  initial begin
    spi_done = 1'b0;
    spi_data = 12'h000;
    forever begin
      @(posedge clk);
      #1;
      spi_done = 1'b0;
      if (!rst_n) begin
        armed = 1'b0;
      end else if (armed) begin
        remain--;
        if (remain <= 0) begin
          spi_done = 1'b1;
          spi_data = base + {9'd0, armChan};
          doneChan = armChan;
          armed    = 1'b0;
        end
      end
      @(negedge clk);
      if (!rst_n) begin
        armed = 1'b0;
      end else if (spi_start && !hang[spi_chan]) begin
        armed   = 1'b1;
        remain  = lat;
        armChan = spi_chan;
      end
    end
  end

  // Continuous observation of request/response pairing.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevDone = 1'b0;
    end else begin
      if (busy) busyCnt++;
      if (spi_start) begin
        startCnt++;
        startQ.push_back(spi_chan);
        checkOutput("start_while_spi_busy", 32'(spi_busy), 32'd0);
      end
      if (scan_done) doneCnt++;
      if (res_valid) begin
        validCnt++;
        checkOutput("res_follows_done", 32'({prevDone, res_chan, res_data}),
                    32'({1'b1, prevChan, prevData}));
      end else if (prevDone) begin
        checkOutput("res_valid_after_done", 32'(res_valid), 32'd1);
      end
      prevDone = spi_done;
      prevData = spi_data;
      prevChan = doneChan;
    end
  end

  task automatic clearCounters();
    startCnt = 0;
    validCnt = 0;
    doneCnt  = 0;
    busyCnt  = 0;
    startQ.delete();
  endtask

  task automatic checkOutputsZero(input string name);
    checkOutput(name, 32'({spi_start, spi_chan, res_valid, res_chan, res_data, scan_done,
                           busy, timeout_err, overrun_err}), 32'd0);
  endtask

  task automatic readAll(input string tag);
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      rd_chan = 3'(c);
      @(negedge clk);
      checkOutput($sformatf("%s_rd%0d", tag, c), 32'(rd_data), 32'(expRes[c]));
    end
  endtask

  task automatic waitScanDone(input int limit);
    bit seen = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (scan_done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("scan_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic pulseClear(input string name);
    @(posedge clk);
    #1;
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    @(negedge clk);
    checkOutput(name, 32'({timeout_err, overrun_err}), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [2:0] expQ[$];
    chan_mask = v.mask;
    lat       = v.lat;
    base      = v.base;
    hang      = 8'h00;
    clearCounters();
    enable = 1'b1;
    waitScanDone(150);
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 8; c++) begin
      if (v.mask[c]) begin
        expRes[c] = v.base + 12'(c);
        expQ.push_back(3'(c));
      end
    end
    checkOutput($sformatf("v%0d_starts", idx), 32'(startCnt), 32'(v.expStarts));
    checkOutput($sformatf("v%0d_valids", idx), 32'(validCnt), 32'(v.expValids));
    checkOutput($sformatf("v%0d_scan_done", idx), 32'(doneCnt), 32'd1);
    checkOutput($sformatf("v%0d_order_len", idx), 32'(startQ.size()), 32'(expQ.size()));
    for (int k = 0; k < expQ.size() && k < startQ.size(); k++) begin
      checkOutput($sformatf("v%0d_order%0d", idx, k), 32'(startQ[k]), 32'(expQ[k]));
    end
    checkOutput($sformatf("v%0d_timeout_err", idx), 32'(timeout_err), 32'd0);
    checkOutput($sformatf("v%0d_overrun_err", idx), 32'(overrun_err), 32'(v.expOv));
    readAll($sformatf("v%0d", idx));
    pulseClear($sformatf("v%0d_clr_err", idx));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int early;
    int firstStart;
    bit found;

    vecs[0] = '{mask: 8'h05, lat: 3,  base: 12'hA00, expStarts: 2, expValids: 2, expOv: 1'b0};
    vecs[1] = '{mask: 8'h80, lat: 1,  base: 12'h100, expStarts: 1, expValids: 1, expOv: 1'b0};
    vecs[2] = '{mask: 8'h5A, lat: 1,  base: 12'hB00, expStarts: 4, expValids: 4, expOv: 1'b0};
    vecs[3] = '{mask: 8'h03, lat: 10, base: 12'hC00, expStarts: 2, expValids: 2, expOv: 1'b1};

    rst_n     = 1'b0;
    enable    = 1'b0;
    chan_mask = 8'h00;
    clr_err   = 1'b0;
    spi_busy  = 1'b0;
    rd_chan   = 3'd0;
    for (int c = 0; c < 8; c++) expRes[c] = 12'h000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutputsZero("reset_outputs");
    readAll("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Empty mask: ticks happen but nothing is ever started.
    clearCounters();
    chan_mask = 8'h00;
    enable    = 1'b1;
    repeat (65) @(posedge clk);
    #1;
    enable = 1'b0;
    checkOutput("empty_mask_starts", 32'(startCnt), 32'd0);
    checkOutput("empty_mask_scan_done", 32'(doneCnt), 32'd0);
    checkOutput("empty_mask_busy", 32'(busyCnt), 32'd0);

    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v], v);
    end

    // Channel 1 never answers: flag must rise exactly 15 cycles after its ISSUE,
    // and a clear in the expiring cycle must lose to the new error.
    chan_mask = 8'h03;
    hang      = 8'h02;
    lat       = 2;
    base      = 12'hD00;
    clearCounters();
    enable = 1'b1;
    found  = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (spi_start && (spi_chan == 3'd1)) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("ch1_issue_seen", 32'(found), 32'd1);
    early = 0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      clr_err = (k == 14);
      @(negedge clk);
      if ((k < 15) && timeout_err) early++;
      if (k == 15) begin
        checkOutput("timeout_at_15", 32'(timeout_err), 32'd1);
        checkOutput("scan_done_after_timeout", 32'(scan_done), 32'd1);
      end
    end
    checkOutput("timeout_not_early", 32'(early), 32'd0);
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expRes[0] = 12'hD00;
    checkOutput("timeout_valids", 32'(validCnt), 32'd1);
    checkOutput("timeout_scan_done_count", 32'(doneCnt), 32'd1);
    readAll("timeout");
    pulseClear("timeout_clr_err");
    hang = 8'h00;

    // SPI engine busy for the first 7 ISSUE cycles.
    chan_mask = 8'h01;
    lat       = 2;
    base      = 12'hE00;
    spi_busy  = 1'b1;
    clearCounters();
    enable = 1'b1;
    found  = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (busy) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("stall_select_seen", 32'(found), 32'd1);
    early = 0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (spi_start) early++;
    end
    @(posedge clk);
    #1;
    spi_busy = 1'b0;
    @(negedge clk);
    checkOutput("start_on_busy_release", 32'(spi_start), 32'd1);
    checkOutput("stall_no_start", 32'(early), 32'd0);
    waitScanDone(40);
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expRes[0] = 12'hE00;
    checkOutput("stall_starts", 32'(startCnt), 32'd1);
    readAll("stall");

    // Reset while waiting for a conversion, then the first request after release.
    chan_mask = 8'h04;
    lat       = 10;
    base      = 12'hF00;
    clearCounters();
    enable = 1'b1;
    found  = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (spi_start) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("pre_reset_start_seen", 32'(found), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutputsZero("midscan_reset_outputs");
    for (int c = 0; c < 8; c++) expRes[c] = 12'h000;
    readAll("midscan_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    firstStart = -1;
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (spi_start && (firstStart < 0)) firstStart = n;
    end
    checkOutput("first_start_after_reset", 32'(firstStart), 32'd21);
    waitScanDone(40);
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expRes[2] = 12'hF02;
    readAll("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
